// File: rtl/sipo_receiver.sv
// sipo_receiver: receive end of the serial link. It collects WIDTH serial bits
// while select=1, assembles them into a parallel word, and presents that word
// through a valid/ready holding register. The overrun flag is sticky.
//
// Parameters:
//   WIDTH     - bits per word (>= 2)
//   MSB_FIRST - 0: the first serial bit lands in data[0];
//               1: the first serial bit lands in data[WIDTH-1]
//   CNT_W     - width of bit_count (derived; do not override)
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high reset
//   enable    - receive-path enable; 0 freezes the shifter and counter
//   select    - 1: din carries a valid bit this cycle; 0: gap (resync)
//   din       - serial data
//   ready     - consumer accepts data when valid=1
//   data      - received parallel word (holding register)
//   valid     - data holds an unconsumed word
//   overrun   - sticky: a completed word was dropped
//   bit_count - bits captured in the current frame, 0..WIDTH-1
module sipo_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             select,
    input  logic             din,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;

    // The shifter holds only the WIDTH-1 bits already received. The completing
    // bit comes straight from din, so the full word is ready on the edge that
    // samples it, with no added latency.
    logic [WIDTH-2:0] shifter;
    logic [WIDTH-1:0] word;
    logic [WIDTH-2:0] shifter_next;
    logic             capture;
    logic             gap;
    logic             complete;

    always_comb begin
        capture  = enable & select;
        gap      = enable & ~select;
        complete = capture && (bit_count == CNT_W'(WIDTH - 1));
        if (MSB_FIRST) begin
            word         = {shifter, din};
            shifter_next = word[WIDTH-2:0];
        end else begin
            word         = {din, shifter};
            shifter_next = word[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shifter   <= '0;
            bit_count <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A consume drops valid. A completion on the same edge re-asserts
            // it further down, and that later assignment takes precedence.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            if (capture) begin
                shifter <= shifter_next;
                if (complete) begin
                    state     <= IDLE;
                    bit_count <= '0;
                    if (!valid || ready) begin
                        data  <= word;
                        valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    state     <= SHIFT;
                    bit_count <= bit_count + CNT_W'(1);
                end
            end else if (gap && state == SHIFT) begin
                state     <= IDLE;
                bit_count <= '0;
                shifter   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_receiver.sv
module tb_sipo_receiver;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          select = 1'b0;
    logic          din = 1'b0;
    logic          ready = 1'b0;
    logic [W-1:0]  data_l, data_m;
    logic          valid_l, valid_m, ovr_l, ovr_m;
    logic [CW-1:0] cnt_l, cnt_m;

    int compared = 0;
    int mismatched = 0;

    // Reference model: the current frame's bits, in arrival order.
    int           mbits[$];
    logic [W-1:0] mdata_l, mdata_m;
    logic         mvalid, movr;

    always #5 clk = ~clk;

    sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .enable(enable), .select(select), .din(din),
        .ready(ready), .data(data_l), .valid(valid_l), .overrun(ovr_l),
        .bit_count(cnt_l)
    );

    sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .enable(enable), .select(select), .din(din),
        .ready(ready), .data(data_m), .valid(valid_m), .overrun(ovr_m),
        .bit_count(cnt_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_lsb",  32'(data_l),  32'(mdata_l));
        chk("data_msb",  32'(data_m),  32'(mdata_m));
        chk("valid_lsb", 32'(valid_l), 32'(mvalid));
        chk("valid_msb", 32'(valid_m), 32'(mvalid));
        chk("ovr_lsb",   32'(ovr_l),   32'(movr));
        chk("ovr_msb",   32'(ovr_m),   32'(movr));
        chk("cnt_lsb",   32'(cnt_l),   32'(mbits.size()));
        chk("cnt_msb",   32'(cnt_m),   32'(mbits.size()));
    endtask

    // Apply inputs for one clock edge, update the model, and check 1 time unit later.
    task automatic step(input logic en, input logic sel, input logic d, input logic rdy);
        logic         old_valid;
        logic [W-1:0] wl, wm;
        enable = en; select = sel; din = d; ready = rdy;
        @(posedge clk);
        old_valid = mvalid;
        if (old_valid && rdy) mvalid = 1'b0;
        if (en && sel) begin
            mbits.push_back(int'(d));
            if (mbits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wl[i]       = mbits[i][0];
                    wm[W-1-i]   = mbits[i][0];
                end
                if (!old_valid || rdy) begin
                    mdata_l = wl; mdata_m = wm; mvalid = 1'b1;
                end else begin
                    movr = 1'b1;
                end
                mbits.delete();
            end
        end else if (en && !sel) begin
            mbits.delete();
        end
        #1;
        check_all();
    endtask

    // Send a word LSB-first on the line; ready applies only to the completing edge.
    task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input logic rdy_rest);
        for (int i = 0; i < W; i++)
            step(1'b1, 1'b1, w[i], (i == W - 1) ? rdy_last : rdy_rest);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        mbits.delete(); mdata_l = '0; mdata_m = '0; mvalid = 1'b0; movr = 1'b0;
        chk("rst_data", 32'(data_l), 32'h0);
        chk("rst_valid", 32'(valid_l), 32'h0);
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        mdata_l = '0; mdata_m = '0; mvalid = 1'b0; movr = 1'b0;
        #12 reset = 1'b0;
        @(posedge clk); #1;

        // T1 reset
        do_reset();

        // T2 basic LSB-first, ready held high
        step(1, 1, 1, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
        chk("t2_data", 32'(data_l), 32'h1);
        chk("t2_data_msb", 32'(data_m), 32'h8);
        chk("t2_valid", 32'(valid_l), 32'h1);
        step(1, 0, 0, 1);
        chk("t2_valid_one_cycle", 32'(valid_l), 32'h0);

        // T3 resync after a gap
        step(1, 1, 0, 1); step(1, 1, 1, 1);
        step(1, 0, 0, 1);
        chk("t3_cnt_gap", 32'(cnt_l), 32'h0);
        step(1, 1, 1, 1); step(1, 1, 1, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
        chk("t3_data", 32'(data_l), 32'hB);
        step(1, 0, 0, 1);

        // T4 overrun with back-to-back frames
        send_word(4'b0011, 0, 0);
        send_word(4'b1010, 0, 0);
        chk("t4_data", 32'(data_l), 32'h3);
        chk("t4_ovr", 32'(ovr_l), 32'h1);
        step(1, 0, 0, 1);
        chk("t4_valid", 32'(valid_l), 32'h0);
        chk("t4_ovr_sticky", 32'(ovr_l), 32'h1);

        // T5 completion and consume on the same edge
        do_reset();
        send_word(4'b0111, 0, 0);
        send_word(4'b1000, 1, 0);
        chk("t5_data", 32'(data_l), 32'h8);
        chk("t5_valid", 32'(valid_l), 32'h1);
        chk("t5_ovr", 32'(ovr_l), 32'h0);
        step(1, 0, 0, 1);

        // T6 freeze, then mid-frame reset
        step(1, 1, 1, 0); step(1, 1, 0, 0);
        step(0, 1, 1, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
        chk("t6_cnt_hold", 32'(cnt_l), 32'h2);
        do_reset();
        send_word(4'b1010, 1, 1);
        chk("t6_data", 32'(data_l), 32'hA);
        chk("t6_valid", 32'(valid_l), 32'h1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(99) == 0) do_reset();
            step(logic'($urandom_range(99) < 85), logic'($urandom_range(99) < 80),
                 logic'($urandom_range(1)), logic'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
